router_pkt_ctrl: RTL
====================

ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the dropped-packet counter.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports pkt_valid  input  1  packet in progress on the input byte stream; datain  input  2  destination address, sampled in DECODE_ADDRESS.
REQ-005 SHALL have ports fifo_full  input  1  selected FIFO full; empty_0/1/2  input  1 each  per-port FIFO empty.
REQ-006 SHALL have ports soft_reset_0/1/2  input  1 each  per-port timeout reset; parity_done  input  1  parity byte written; low_pkt_valid  input  1  pkt_valid fell while FIFO was full.
REQ-007 SHALL have outputs detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy  output  1 each  state decodes.
REQ-008 SHALL have output addr_err  output  1  one-cycle pulse on packet with address 2'b11.
REQ-009 SHALL have output drop_cnt  output  ERR_CNT_W  dropped-packet count (present only under REQ-024).

Function
REQ-010 SHALL implement a registered Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY; all outputs except addr_err decode from the current state only.
REQ-011 SHALL latch datain into addr_q on each clock while in DECODE_ADDRESS with pkt_valid=1; sel_empty and sel_soft_reset SHALL be the empty_x/soft_reset_x selected by addr_q (datain while in DECODE_ADDRESS).
REQ-012 DECODE_ADDRESS: detect_add=1; pkt_valid & datain<3 & empty of datain -> LOAD_FIRST_DATA; pkt_valid & datain<3 & not empty -> WAIT_TILL_EMPTY; pkt_valid & datain==3 -> stay, addr_err=1 for that cycle; otherwise stay.
REQ-013 LOAD_FIRST_DATA: lfd_state=1, busy=1; -> LOAD_DATA unconditionally (1 cycle).
REQ-014 LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0; fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority when both occur.
REQ-015 FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0; !fifo_full -> LOAD_AFTER_FULL; else stay.
REQ-016 LOAD_AFTER_FULL: laf_state=1, write_enb_reg=1, busy=1; parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-017 LOAD_PARITY: write_enb_reg=1, busy=1; -> CHECK_PARITY_ERROR.
REQ-018 CHECK_PARITY_ERROR: rst_int_reg=1, busy=1; fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-019 WAIT_TILL_EMPTY: busy=1, write_enb_reg=0; sel_empty -> LOAD_FIRST_DATA; else stay.
REQ-020 sel_soft_reset=1 in any state other than DECODE_ADDRESS SHALL force next state DECODE_ADDRESS, overriding every other transition.
REQ-021 Unlisted outputs SHALL be 0 in each state; illegal state encodings SHALL return to DECODE_ADDRESS next cycle.

Reset
REQ-022 reset=1 SHALL immediately force state=DECODE_ADDRESS, addr_q=0, drop_cnt=0, independent of clk.
REQ-023 During and after reset outputs SHALL be detect_add=1, all other state decodes 0, busy=0, addr_err=0; reset mid-packet abandons the packet without further write_enb_reg.

Configuration
REQ-024 Macro ROUTER_PKT_CTRL_DROP_CNT_EN defined: drop_cnt increments by 1 on each addr_err pulse and on each soft-reset-forced exit (REQ-020), saturating at all-ones; both events in one cycle count once. Undefined: drop_cnt port and counter SHALL be absent; FSM behaviour identical.

Structure
REQ-025 Shared package router_pkg SHALL hold the state enum, port address constants PORT0=2'b00, PORT1=2'b01, PORT2=2'b10, ADDR_INVALID=2'b11.
REQ-026 Saturating counter SHALL be sub-module router_drop_cnt, instantiated only under ROUTER_PKT_CTRL_DROP_CNT_EN.

Verification
REQ-027 Reset, then pkt_valid=1, datain=01, empty_1=1 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA (write_enb_reg=1); drop pkt_valid -> LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
REQ-028 In LOAD_DATA assert fifo_full=1 and pkt_valid=0 together -> FIFO_FULL_STATE (write_enb_reg=0); release fifo_full -> LOAD_AFTER_FULL; with low_pkt_valid=1 -> LOAD_PARITY.
REQ-029 datain=10, empty_2=0 -> WAIT_TILL_EMPTY held 5 cycles, busy=1; empty_2=1 -> LOAD_FIRST_DATA.
REQ-030 In WAIT_TILL_EMPTY for port 0 assert soft_reset_0 -> DECODE_ADDRESS next cycle; soft_reset_1 alone -> no effect; with macro, drop_cnt 0->1.
REQ-031 pkt_valid=1, datain=11 for 3 cycles -> stays DECODE_ADDRESS, addr_err=1 each cycle; with macro and ERR_CNT_W=2, drop_cnt 0,1,2,3 then holds 3 on a 4th.
REQ-032 Assert reset asynchronously mid-LOAD_DATA -> detect_add=1, write_enb_reg=0 before next clk edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router packet controller: FSM state encoding,
// port address constants and the per-state control decode.
package router_pkg;

  localparam logic [1:0] PORT0        = 2'b00;
  localparam logic [1:0] PORT1        = 2'b01;
  localparam logic [1:0] PORT2        = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic write_enb_reg;
    logic rst_int_reg;
    logic busy;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '{default: 1'b0};
    case (s)
      DECODE_ADDRESS:     c.detect_add = 1'b1;
      LOAD_FIRST_DATA:    begin c.lfd_state = 1'b1; c.busy = 1'b1; end
      LOAD_DATA:          begin c.ld_state = 1'b1; c.write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin c.full_state = 1'b1; c.busy = 1'b1; end
      LOAD_AFTER_FULL:    begin c.laf_state = 1'b1; c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      LOAD_PARITY:        begin c.write_enb_reg = 1'b1; c.busy = 1'b1; end
      CHECK_PARITY_ERROR: begin c.rst_int_reg = 1'b1; c.busy = 1'b1; end
      WAIT_TILL_EMPTY:    c.busy = 1'b1;
      default:            c.detect_add = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/router_drop_cnt.sv
// Saturating event counter for dropped packets; holds at all-ones.
module router_drop_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count increment events, saturating at the maximum value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {W{1'b0}};
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/router_pkt_ctrl.sv
// Router packet controller FSM. Optional dropped-packet counter is built
// when ROUTER_PKT_CTRL_DROP_CNT_EN is defined.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pkt_valid,
  input  logic [1:0] datain,
  input  logic fifo_full,
  input  logic empty_0,
  input  logic empty_1,
  input  logic empty_2,
  input  logic soft_reset_0,
  input  logic soft_reset_1,
  input  logic soft_reset_2,
  input  logic parity_done,
  input  logic low_pkt_valid,
  output logic detect_add,
  output logic lfd_state,
  output logic ld_state,
  output logic laf_state,
  output logic full_state,
  output logic write_enb_reg,
  output logic rst_int_reg,
  output logic busy,
  output logic addr_err
`ifdef ROUTER_PKT_CTRL_DROP_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] drop_cnt
`endif
);

  if (ERR_CNT_W < 1) begin : g_bad_width
    $error("router_pkt_ctrl: ERR_CNT_W must be at least 1");
  end

  state_t     state_r;
  state_t     nxt_s;
  logic [1:0] addr_q_r;
  logic [1:0] sel_addr_s;
  logic       sel_empty_s;
  logic       sel_soft_reset_s;
  ctrl_t      ctrl_r;

  // While decoding, the live address picks the port; afterwards the latched one
  always_comb begin
    sel_addr_s       = (state_r == DECODE_ADDRESS) ? datain : addr_q_r;
    sel_empty_s      = 1'b0;
    sel_soft_reset_s = 1'b0;
    case (sel_addr_s)
      PORT0:   begin sel_empty_s = empty_0; sel_soft_reset_s = soft_reset_0; end
      PORT1:   begin sel_empty_s = empty_1; sel_soft_reset_s = soft_reset_1; end
      PORT2:   begin sel_empty_s = empty_2; sel_soft_reset_s = soft_reset_2; end
      default: begin sel_empty_s = 1'b0;    sel_soft_reset_s = 1'b0;         end
    endcase
  end

  assign addr_err = (state_r == DECODE_ADDRESS) && pkt_valid && (datain == ADDR_INVALID);

  // Next-state rules; a port soft reset outside decode overrides everything
  always_comb begin
    nxt_s = DECODE_ADDRESS;
    if ((state_r != DECODE_ADDRESS) && sel_soft_reset_s) begin
      nxt_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid && (datain != ADDR_INVALID)) begin
            nxt_s = sel_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end else begin
            nxt_s = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: nxt_s = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       nxt_s = FIFO_FULL_STATE;
          else if (!pkt_valid) nxt_s = LOAD_PARITY;
          else                 nxt_s = LOAD_DATA;
        end
        FIFO_FULL_STATE: nxt_s = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        nxt_s = DECODE_ADDRESS;
          else if (low_pkt_valid) nxt_s = LOAD_PARITY;
          else                    nxt_s = LOAD_DATA;
        end
        LOAD_PARITY:        nxt_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt_s = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    nxt_s = sel_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:            nxt_s = DECODE_ADDRESS;
      endcase
    end
  end

  // State, latched address and registered state decodes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= DECODE_ADDRESS;
      addr_q_r <= 2'b00;
      ctrl_r   <= decode_state(DECODE_ADDRESS);
    end else begin
      state_r <= nxt_s;
      ctrl_r  <= decode_state(nxt_s);
      if ((state_r == DECODE_ADDRESS) && pkt_valid) begin
        addr_q_r <= datain;
      end else begin
        addr_q_r <= addr_q_r;
      end
    end
  end

  assign detect_add    = ctrl_r.detect_add;
  assign lfd_state     = ctrl_r.lfd_state;
  assign ld_state      = ctrl_r.ld_state;
  assign laf_state     = ctrl_r.laf_state;
  assign full_state    = ctrl_r.full_state;
  assign write_enb_reg = ctrl_r.write_enb_reg;
  assign rst_int_reg   = ctrl_r.rst_int_reg;
  assign busy          = ctrl_r.busy;

`ifdef ROUTER_PKT_CTRL_DROP_CNT_EN
  logic drop_inc_s;
  assign drop_inc_s = addr_err || ((state_r != DECODE_ADDRESS) && sel_soft_reset_s);

  router_drop_cnt #(.W(ERR_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc_s),
    .cnt   (drop_cnt)
  );
`endif

endmodule
